operand_capture: RTL and testbench

OPERAND_CAPTURE -- requirements
Module: operand_capture

---
 rtl/operand_capture_pkg.sv | 17 +
 rtl/operand_capture_db_cell.sv | 45 ++++
 rtl/operand_capture_tick_gen.sv | 26 ++
 rtl/operand_capture.sv | 113 +++++++++++
 tb/tb_operand_capture.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/operand_capture_pkg.sv
// Shared types and default parameter values for the operand capture block.
package operand_capture_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLDING,
    VALID,
    WAIT_RELEASE
  } cap_state_t;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_N_CH        = 2;
  localparam int DEF_TICK_CYCLES = 250000;
  localparam int DEF_DB_SAMPLES  = 4;
  localparam int DEF_HOLD_CYCLES = 50000000;

endpackage

// File: rtl/operand_capture_db_cell.sv
// One debounced input: 2-flop synchroniser, tick-sampled shift register and
// a hysteresis bit that only moves when every stored sample agrees.
module db_cell
  import operand_capture_pkg::*;
#(
  parameter int DB_SAMPLES = DEF_DB_SAMPLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic level_next
);

  logic [1:0]            sync_q, sync_d;
  logic [DB_SAMPLES-1:0] shift_q, shift_d;
  logic                  level_q, level_d;

  always_comb begin
    sync_d  = {sync_q[0], raw};
    shift_d = shift_q;
    if (tick) shift_d = {shift_q[DB_SAMPLES-2:0], sync_q[1]};
    level_d = level_q;
    if (&shift_q)       level_d = 1'b1;
    else if (~|shift_q) level_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      shift_q <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      shift_q <= shift_d;
      level_q <= level_d;
    end
  end

  // level_next lets the consumer react on the very edge the level register flips.
  assign level      = level_q;
  assign level_next = level_d;

endmodule

// File: rtl/operand_capture_tick_gen.sv
// Free-running sample tick: one-cycle pulse every TICK_CYCLES clocks.
module tick_gen
  import operand_capture_pkg::*;
#(
  parameter int TICK_CYCLES = DEF_TICK_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(TICK_CYCLES - 1));
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/operand_capture.sv
// Debounces switch banks and a start button; a long press captures the
// switch values as operands and holds them until the consumer acknowledges.
module operand_capture
  import operand_capture_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int N_CH        = DEF_N_CH,
  parameter int TICK_CYCLES = DEF_TICK_CYCLES,
  parameter int DB_SAMPLES  = DEF_DB_SAMPLES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                   CLK100MHZ,
  input  logic                   reset,
  input  logic [N_CH*WIDTH-1:0]  sw,
  input  logic                   pb,
  input  logic                   ack,
  output logic [N_CH*WIDTH-1:0]  operands,
  output logic                   valid,
  output logic [N_CH*WIDTH-1:0]  LED,
  output logic                   LED_pb,
  output logic                   LED_busy
);

  localparam int NBITS = N_CH * WIDTH;
  localparam int HCW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic             tick;
  logic [NBITS:0]   raw_all;
  logic [NBITS:0]   lvl;
  logic [NBITS:0]   lvl_next;
  logic             pb_db;

  cap_state_t       state_q, state_d;
  logic [HCW-1:0]   hold_q, hold_d;
  logic [NBITS-1:0] ops_q, ops_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk   (CLK100MHZ),
    .rst_n (reset),
    .tick  (tick)
  );

  assign raw_all = {pb, sw};

  // Bit NBITS is the pushbutton; the rest are switches in port order.
  for (genvar gi = 0; gi <= NBITS; gi++) begin : g_db
    db_cell #(.DB_SAMPLES(DB_SAMPLES)) u_db (
      .clk        (CLK100MHZ),
      .rst_n      (reset),
      .tick       (tick),
      .raw        (raw_all[gi]),
      .level      (lvl[gi]),
      .level_next (lvl_next[gi])
    );
  end

  assign pb_db = lvl_next[NBITS];

  always_comb begin
    state_d = state_q;
    hold_d  = '0;
    ops_d   = ops_q;
    case (state_q)
      IDLE: begin
        if (pb_db) state_d = HOLDING;
      end
      HOLDING: begin
        if (!pb_db) begin
          state_d = IDLE;
        end else if (hold_q == HCW'(HOLD_CYCLES - 1)) begin
          state_d = VALID;
          ops_d   = lvl_next[NBITS-1:0];
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      VALID: begin
        if (ack) state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (!pb_db) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == VALID);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      ops_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ops_q   <= ops_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign operands = ops_q;
  assign valid    = valid_q;
  assign LED      = lvl[NBITS-1:0];
  assign LED_pb   = lvl[NBITS];
  assign LED_busy = busy_q;

endmodule

// File: tb/tb_operand_capture.sv
// Directed bench for operand_capture: a scoreboard of expected captures is
// checked by a monitor on each valid rise; other checks are inline.
module tb_operand_capture;

  localparam int W  = 8;
  localparam int NC = 2;
  localparam int TC = 4;
  localparam int DS = 4;
  localparam int HC = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sw = 16'h0;
  logic        pb = 1'b0;
  logic        ack = 1'b0;
  logic [15:0] operands, led;
  logic        valid, led_pb, led_busy;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  operand_capture #(
    .WIDTH(W), .N_CH(NC), .TICK_CYCLES(TC), .DB_SAMPLES(DS), .HOLD_CYCLES(HC)
  ) dut (
    .CLK100MHZ (clk),
    .reset     (rst_n),
    .sw        (sw),
    .pb        (pb),
    .ack       (ack),
    .operands  (operands),
    .valid     (valid),
    .LED       (led),
    .LED_pb    (led_pb),
    .LED_busy  (led_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pb(input logic lvl);
    int n = 0;
    while (led_pb !== lvl && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("wait_led_pb", 32'(led_pb), 32'(lvl));
  endtask

  task automatic wait_valid();
    int n = 0;
    while (valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid", 32'(valid), 32'd1);
  endtask

  task automatic wait_led(input logic [15:0] v);
    int n = 0;
    while (led !== v && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("wait_led", 32'(led), 32'(v));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_operands"}, 32'(operands), 32'd0);
    chk({tag, "_valid"},    32'(valid),    32'd0);
    chk({tag, "_led"},      32'(led),      32'd0);
    chk({tag, "_led_pb"},   32'(led_pb),   32'd0);
    chk({tag, "_busy"},     32'(led_busy), 32'd0);
  endtask

  // Monitor: on each valid rise, pop the expected operands and check the
  // press-to-valid latency measured from the LED_pb rise.
  initial begin
    logic        pv, vv;
    int          cyc, rise, lat;
    logic [15:0] exp_ops;
    pv = 1'b0; vv = 1'b0; cyc = 0; rise = 0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (led_pb === 1'b1 && pv !== 1'b1) rise = cyc;
      if (valid === 1'b1 && vv !== 1'b1) begin
        lat = cyc - rise;
        $display("capture: operands=%h latency=%0d", operands, lat);
        chk("capture_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          exp_ops = sb_q.pop_front();
          chk("capture_operands", 32'(operands), 32'(exp_ops));
          chk("capture_latency", 32'(lat), 32'(HC));
        end
      end
      pv = led_pb;
      vv = valid;
    end
  end

  initial begin
    logic [1:0] seen;

    // Reset state
    cycles(3);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    cycles(2);

    // One-tick glitches on sw[3] and pb must not pass the debouncer
    seen = 2'b00;
    sw[3] = 1'b1;
    pb = 1'b1;
    repeat (TC) begin
      @(negedge clk);
      seen |= {led[3], led_pb};
    end
    sw[3] = 1'b0;
    pb = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen |= {led[3], led_pb};
    end
    chk("glitch_filtered", 32'(seen), 32'd0);
    chk("glitch_busy", 32'(led_busy), 32'd0);

    // Full-length press captures 7F85
    sw = 16'h7F85;
    wait_led(16'h7F85);
    sb_q.push_back(16'h7F85);
    pb = 1'b1;
    wait_pb(1'b1);
    wait_valid();
    cycles(20);

    // Switch change and button release while VALID
    sw = 16'h0001;
    pb = 1'b0;
    cycles(30);
    chk("valid_held", 32'(valid), 32'd1);
    chk("operands_held", 32'(operands), 32'h7F85);
    chk("led_follows_sw", 32'(led), 32'h0001);
    chk("led_pb_released", 32'(led_pb), 32'd0);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("ack_drops_valid", 32'(valid), 32'd0);
    chk("ack_wait_release_busy", 32'(led_busy), 32'd1);
    @(negedge clk);
    chk("ack_back_to_idle", 32'(led_busy), 32'd0);
    chk("operands_kept_after_ack", 32'(operands), 32'h7F85);

    // Short press: debounced pb drops before the hold completes
    pb = 1'b1;
    wait_pb(1'b1);
    pb = 1'b0;
    wait_pb(1'b0);
    @(negedge clk);
    chk("short_press_valid", 32'(valid), 32'd0);
    chk("short_press_idle", 32'(led_busy), 32'd0);

    // Reset at hold count 15 aborts; a full hold is needed afterwards
    pb = 1'b1;
    wait_pb(1'b1);
    cycles(15);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midhold_reset");
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.push_back(16'h0001);
    wait_pb(1'b1);
    wait_valid();

    // Ack while the button is still held: no recapture until release
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("held_ack_valid", 32'(valid), 32'd0);
    cycles(40);
    chk("held_wait_busy", 32'(led_busy), 32'd1);
    chk("held_no_recapture", 32'(valid), 32'd0);
    pb = 1'b0;
    wait_pb(1'b0);
    @(negedge clk);
    chk("held_release_idle", 32'(led_busy), 32'd0);

    // Ack in IDLE is ignored
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_busy", 32'(led_busy), 32'd0);
    chk("idle_ack_valid", 32'(valid), 32'd0);

    // Ack in the same cycle the debounced button falls. Valid rises one edge
    // after a tick edge, so releasing here puts the fourth zero sample
    // 15 edges later and the debounced fall on the edge after that.
    sw = 16'hA53C;
    wait_led(16'hA53C);
    sb_q.push_back(16'hA53C);
    pb = 1'b1;
    wait_pb(1'b1);
    wait_valid();
    pb = 1'b0;
    cycles(15);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("same_cycle_valid", 32'(valid), 32'd0);
    chk("same_cycle_led_pb", 32'(led_pb), 32'd0);
    chk("same_cycle_wait_release", 32'(led_busy), 32'd1);
    @(negedge clk);
    chk("same_cycle_idle", 32'(led_busy), 32'd0);
    chk("same_cycle_operands", 32'(operands), 32'hA53C);

    cycles(5);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
